// File: rtl/arrow_sequencer_pkg.sv
// Shared DDR game definitions: arrow codes, default generator settings and
// sequencer state codes.
package arrow_sequencer_pkg;

  localparam int unsigned DDR_LFSR_WIDTH   = 16;
  localparam logic [15:0] DDR_TAPS         = 16'hB400;
  localparam logic [15:0] DDR_DEFAULT_SEED = 16'hACE1;
  localparam int unsigned DDR_NUM_ARROWS   = 4;
  localparam int unsigned DDR_ARROW_BITS   = 2;
  localparam int unsigned DDR_QUEUE_DEPTH  = 4;

  localparam logic [1:0] ARROW_LEFT  = 2'd0;
  localparam logic [1:0] ARROW_DOWN  = 2'd1;
  localparam logic [1:0] ARROW_UP    = 2'd2;
  localparam logic [1:0] ARROW_RIGHT = 2'd3;

  // Sequencer states kept as plain constants for compatibility with legacy code.
  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci-style LFSR holding the generator state; handles load with zero
// substitution and single-step advance.
module lfsr_core #(
  parameter int unsigned   W            = 16,
  parameter logic [W-1:0]  TAPS         = 16'hB400,
  parameter logic [W-1:0]  DEFAULT_SEED = 16'hACE1,
  parameter int unsigned   OUT_BITS     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [W-1:0]        load_value,
  input  logic                advance,
  output logic [W-1:0]        state,
  output logic [OUT_BITS-1:0] next_low
);

  logic [W-1:0] state_q, state_d;
  logic [W-1:0] next_state;
  logic         fb;

  // Next-state: load beats advance; a zero load is replaced by the default seed.
  always_comb begin
    fb         = ^(state_q & TAPS);
    next_state = {state_q[W-2:0], fb};
    state_d    = state_q;
    if (load) begin
      state_d = (load_value == '0) ? DEFAULT_SEED : load_value;
    end else if (advance) begin
      state_d = next_state;
    end
  end

  // State register with synchronous reset to the default seed.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DEFAULT_SEED;
    else     state_q <= state_d;
  end

  assign state    = state_q;
  assign next_low = next_state[OUT_BITS-1:0];

endmodule

// File: rtl/arrow_sequencer.sv
// DDR arrow generator: fills a look-ahead queue from an LFSR, then shifts one
// new arrow in per beat step, with range folding and optional no-repeat.
module arrow_sequencer
  import arrow_sequencer_pkg::*;
#(
  parameter int unsigned            LFSR_WIDTH   = DDR_LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0]  TAPS         = DDR_TAPS,
  parameter logic [LFSR_WIDTH-1:0]  DEFAULT_SEED = DDR_DEFAULT_SEED,
  parameter int unsigned            NUM_ARROWS   = DDR_NUM_ARROWS,
  parameter int unsigned            ARROW_BITS   = DDR_ARROW_BITS,
  parameter int unsigned            QUEUE_DEPTH  = DDR_QUEUE_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              step,
  input  logic                              seed_load,
  input  logic [LFSR_WIDTH-1:0]             seed,
  input  logic                              no_repeat,
  output logic [ARROW_BITS-1:0]             head_arrow,
  output logic [QUEUE_DEPTH*ARROW_BITS-1:0] arrow_queue,
  output logic                              arrow_valid,
  output logic [LFSR_WIDTH-1:0]             lfsr_state
);

  localparam int unsigned CNT_W = (QUEUE_DEPTH > 2) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned AW    = ARROW_BITS + 1;
  localparam logic [AW-1:0]    NA        = AW'(NUM_ARROWS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(QUEUE_DEPTH - 1);

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [ARROW_BITS-1:0] queue_q [QUEUE_DEPTH];
  logic [ARROW_BITS-1:0] queue_d [QUEUE_DEPTH];

  logic [ARROW_BITS-1:0] raw;
  logic [AW-1:0]         cand_w, inc_w;
  logic [ARROW_BITS-1:0] pred;
  logic [CNT_W-1:0]      pred_idx;
  logic                  has_pred;
  logic [ARROW_BITS-1:0] arrow_new;
  logic                  advance;

  lfsr_core #(
    .W            (LFSR_WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED),
    .OUT_BITS     (ARROW_BITS)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (seed_load),
    .load_value (seed),
    .advance    (advance),
    .state      (lfsr_state),
    .next_low   (raw)
  );

  // Candidate arrow from the advanced LFSR, folded into range, then bumped if
  // it would repeat the most recently written arrow.
  always_comb begin
    cand_w   = {1'b0, raw};
    if (cand_w >= NA) cand_w = cand_w - NA;
    inc_w    = cand_w + AW'(1);
    if (inc_w == NA) inc_w = '0;
    pred_idx = fill_cnt_q - CNT_W'(1);
    if (state_q == ST_FILL) begin
      has_pred = (fill_cnt_q != '0);
      pred     = queue_q[pred_idx];
    end else begin
      has_pred = 1'b1;
      pred     = queue_q[QUEUE_DEPTH-1];
    end
    if (no_repeat && has_pred && (cand_w == {1'b0, pred})) arrow_new = ARROW_BITS'(inc_w);
    else                                                   arrow_new = ARROW_BITS'(cand_w);
  end

  // FILL/READY control and queue update; seed_load overrides step.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    queue_d    = queue_q;
    advance    = 1'b0;
    if (seed_load) begin
      state_d    = ST_FILL;
      fill_cnt_d = '0;
    end else if (state_q == ST_FILL) begin
      advance             = 1'b1;
      queue_d[fill_cnt_q] = arrow_new;
      if (fill_cnt_q == LAST_SLOT) begin
        state_d    = ST_READY;
        fill_cnt_d = '0;
      end else begin
        fill_cnt_d = fill_cnt_q + CNT_W'(1);
      end
    end else if (step) begin
      advance = 1'b1;
      for (int unsigned k = 0; k < QUEUE_DEPTH - 1; k++) queue_d[k] = queue_q[k+1];
      queue_d[QUEUE_DEPTH-1] = arrow_new;
    end
  end

  // Control and queue registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      for (int unsigned k = 0; k < QUEUE_DEPTH; k++) queue_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      queue_q    <= queue_d;
    end
  end

  // Flatten the queue for the display; slot 0 sits in the low bits.
  always_comb begin
    arrow_queue = '0;
    for (int unsigned k = 0; k < QUEUE_DEPTH; k++)
      arrow_queue[k*ARROW_BITS +: ARROW_BITS] = queue_q[k];
  end

  assign head_arrow  = queue_q[0];
  assign arrow_valid = (state_q == ST_READY);

endmodule

// File: tb/tb_arrow_sequencer.sv
// Bench for arrow_sequencer: two instances (4 and 3 arrows) share stimulus and
// are compared every cycle against a queue-based reference model, plus a table
// of known seeds and hand-written corner sequences.
module tb_arrow_sequencer;

  logic        clk = 1'b0;
  logic        rst, step, seed_load, no_repeat;
  logic [15:0] seed;

  logic [1:0]  h4, h3;
  logic [7:0]  q4, q3;
  logic        v4, v3;
  logic [15:0] l4, l3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arrow_sequencer u_dut4 (
    .clk(clk), .rst(rst), .step(step), .seed_load(seed_load), .seed(seed),
    .no_repeat(no_repeat), .head_arrow(h4), .arrow_queue(q4),
    .arrow_valid(v4), .lfsr_state(l4)
  );

  arrow_sequencer #(.NUM_ARROWS(3), .ARROW_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .step(step), .seed_load(seed_load), .seed(seed),
    .no_repeat(no_repeat), .head_arrow(h3), .arrow_queue(q3),
    .arrow_valid(v3), .lfsr_state(l3)
  );

  // Reference model: logical queue of generated arrows plus what each slot shows.
  int unsigned m_lfsr;
  int          m_q     [2][$];
  int          m_shown [2][4];
  int          na      [2] = '{4, 3};

  function automatic int unsigned lfsr_adv(int unsigned x);
    int unsigned fb = 0;
    for (int b = 0; b < 16; b++) if (((16'hB400 >> b) & 1) != 0 && ((x >> b) & 1) != 0) fb ^= 1;
    return ((x << 1) & 16'hFFFF) | fb;
  endfunction

  function automatic int pick(int n, int unsigned nxt, bit has_pred, int pred, bit nr);
    int raw  = int'(nxt % 4);
    int cand = (raw >= n) ? raw - n : raw;
    if (nr && has_pred && cand == pred) return (cand + 1) % n;
    return cand;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_lfsr = 16'hACE1;
      for (int i = 0; i < 2; i++) begin
        m_q[i].delete();
        for (int k = 0; k < 4; k++) m_shown[i][k] = 0;
      end
    end else if (seed_load) begin
      m_lfsr = (seed == 16'h0) ? 16'hACE1 : int'(seed);
      for (int i = 0; i < 2; i++) m_q[i].delete();
    end else if (m_q[0].size() < 4) begin
      m_lfsr = lfsr_adv(m_lfsr);
      for (int i = 0; i < 2; i++) begin
        int a = pick(na[i], m_lfsr, m_q[i].size() > 0,
                     (m_q[i].size() > 0) ? m_q[i][$] : 0, no_repeat);
        m_q[i].push_back(a);
        m_shown[i][m_q[i].size()-1] = a;
      end
    end else if (step) begin
      m_lfsr = lfsr_adv(m_lfsr);
      for (int i = 0; i < 2; i++) begin
        int a = pick(na[i], m_lfsr, 1'b1, m_q[i][$], no_repeat);
        void'(m_q[i].pop_front());
        m_q[i].push_back(a);
        for (int k = 0; k < 4; k++) m_shown[i][k] = m_q[i][k];
      end
    end
  endtask

  function automatic logic [7:0] m_pack(int i);
    logic [7:0] p = '0;
    for (int k = 0; k < 4; k++) p[k*2 +: 2] = 2'(m_shown[i][k]);
    return p;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic mv = (m_q[0].size() == 4);
    chk("m_valid4", 32'(v4), 32'(mv));
    chk("m_valid3", 32'(v3), 32'(mv));
    chk("m_lfsr4",  32'(l4), m_lfsr);
    chk("m_lfsr3",  32'(l3), m_lfsr);
    chk("m_queue4", 32'(q4), 32'(m_pack(0)));
    chk("m_queue3", 32'(q3), 32'(m_pack(1)));
    chk("m_head4",  32'(h4), 32'(m_shown[0][0]));
    chk("m_head3",  32'(h3), 32'(m_shown[1][0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic [15:0] seed;
    logic        nr;
    logic [7:0]  exp_q4;
    logic [7:0]  exp_q3;
    logic [15:0] exp_lfsr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{16'h0001, 1'b0, 8'h02, 8'h02, 16'h0010};
    vecs[1] = '{16'h8001, 1'b0, 8'h0B, 8'h08, 16'h0018};
    vecs[2] = '{16'h8001, 1'b1, 8'h4B, 8'h48, 16'h0018};
    vecs[3] = '{16'h0001, 1'b1, 8'h12, 8'h12, 16'h0010};

    rst = 1'b1; step = 1'b0; seed_load = 1'b0; seed = '0; no_repeat = 1'b0;
    cycle();
    cycle();
    chk("rst_lfsr",  32'(l4), 32'hACE1);
    chk("rst_queue", 32'(q4), 32'h0);
    chk("rst_valid", 32'(v4), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("valid_after_rst", 32'(v4), 32'(k == 3));
    end
    chk("lfsr_nonzero", 32'(l4 != 16'h0), 32'h1);

    // Known seeds: valid rises on the 4th edge after the load edge.
    for (int i = 0; i < 4; i++) begin
      seed = vecs[i].seed; no_repeat = vecs[i].nr; seed_load = 1'b1;
      cycle();
      seed_load = 1'b0;
      chk("load_valid", 32'(v4), 32'h0);
      for (int k = 0; k < 4; k++) begin
        cycle();
        chk("fill_valid", 32'(v4), 32'(k == 3));
      end
      chk("tbl_queue4", 32'(q4), 32'(vecs[i].exp_q4));
      chk("tbl_queue3", 32'(q3), 32'(vecs[i].exp_q3));
      chk("tbl_lfsr",   32'(l4), 32'(vecs[i].exp_lfsr));
      chk("tbl_head",   32'(h4), 32'(vecs[i].exp_q4[1:0]));
    end

    // No-repeat step after seed 0001: candidate 0 equals tail 0, bumped to 1.
    step = 1'b1;
    cycle();
    step = 1'b0;
    chk("nr_step_lfsr",  32'(l4), 32'h0020);
    chk("nr_step_queue", 32'(q4), 32'h44);
    cycle();
    chk("hold_queue", 32'(q4), 32'h44);
    chk("hold_lfsr",  32'(l4), 32'h0020);

    // Zero seed substitutes the default.
    seed = 16'h0; no_repeat = 1'b0; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    chk("zero_seed_lfsr", 32'(l4), 32'hACE1);

    // Steps during FILL are ignored.
    seed = 16'h0001; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0; step = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    step = 1'b0;
    chk("fill_step_queue", 32'(q4), 32'h02);
    chk("fill_step_lfsr",  32'(l4), 32'h0010);
    chk("fill_step_valid", 32'(v4), 32'h1);

    // seed_load wins over step in READY.
    seed = 16'h8001; seed_load = 1'b1; step = 1'b1;
    cycle();
    seed_load = 1'b0; step = 1'b0;
    chk("load_step_valid", 32'(v4), 32'h0);
    chk("load_step_lfsr",  32'(l4), 32'h8001);
    chk("load_step_queue", 32'(q4), 32'h02);

    // Reset mid-fill.
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midfill_rst_queue", 32'(q4), 32'h0);
    chk("midfill_rst_lfsr",  32'(l4), 32'hACE1);
    chk("midfill_rst_valid", 32'(v4), 32'h0);

    // Randomized stimulus against the model.
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 149) == 0);
      seed_load = ($urandom_range(0, 39) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      step      = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) no_repeat = ~no_repeat;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
